// File: rtl/adc_result_buffer.sv
// Averages SAR ADC codes over 2^avg_sel samples (one capture per EOC rise) and
// queues each result in a first-word fall-through FIFO with a sticky overflow flag.
module adc_result_buffer #(
   parameter int unsigned NUM_BITS = 4,
   parameter int unsigned DEPTH    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_BITS-1:0]        D_in,
   input  logic                       EOC,
   input  logic [1:0]                 avg_sel,
   input  logic                       clr,
   input  logic                       out_ready,
   output logic [NUM_BITS-1:0]        out_data,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int unsigned AW = NUM_BITS + 3;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = 4;

   logic                eoc_q, eoc_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [SW-1:0]       cnt_q, cnt_d;
   logic [1:0]          win_sel_q, win_sel_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                valid_q, valid_d;
   logic [NUM_BITS-1:0] head_q, head_d;
   logic [NUM_BITS-1:0] mem_q [DEPTH];

   logic                cap, last, pop, full, push, mem_we;
   logic [1:0]          sel_eff;
   logic [AW-1:0]       sum;
   logic [NUM_BITS-1:0] result;

   // Capture, averaging and FIFO next-state; clr overrides everything.
   always_comb begin
      eoc_d     = EOC;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      win_sel_d = win_sel_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      mem_we    = 1'b0;

      cap     = EOC && !eoc_q;
      sel_eff = (cnt_q == '0) ? avg_sel : win_sel_q;
      sum     = acc_q + AW'(D_in);
      last    = cap && ((cnt_q + SW'(1)) == (SW'(1) << sel_eff));
      result  = NUM_BITS'(sum >> sel_eff);
      pop     = valid_q && out_ready;
      full    = (count_q == CW'(DEPTH));
      push    = last && (!full || pop);

      if (cap) begin
         if (cnt_q == '0) win_sel_d = avg_sel;
         if (last) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + SW'(1);
         end
      end

      if (last && full && !pop) ovf_d = 1'b1;

      if (push) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      if (push && (wr_ptr_q == rd_ptr_d)) head_d = result;
      else                                head_d = mem_q[rd_ptr_d];

      if (clr) begin
         eoc_d    = EOC;
         acc_d    = '0;
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         mem_we   = 1'b0;
         head_d   = '0;
      end

      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eoc_q     <= 1'b1;
         acc_q     <= '0;
         cnt_q     <= '0;
         win_sel_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         head_q    <= '0;
      end else begin
         eoc_q     <= eoc_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         win_sel_q <= win_sel_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         head_q    <= head_d;
      end
   end

   // Storage array; cleared on reset so the head is never unknown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[wr_ptr_q] <= result;
      end
   end

   assign out_data  = head_q;
   assign out_valid = valid_q;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_adc_result_buffer.sv
// Directed self-checking bench for adc_result_buffer (NUM_BITS=4, DEPTH=8).
module tb_adc_result_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] D_in;
   logic       EOC;
   logic [1:0] avg_sel;
   logic       clr;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic [3:0] count;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   adc_result_buffer #(.NUM_BITS(4), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .D_in(D_in), .EOC(EOC), .avg_sel(avg_sel),
      .clr(clr), .out_ready(out_ready), .out_data(out_data),
      .out_valid(out_valid), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic pulse(input logic [3:0] code);
      @(negedge clk);
      D_in = code;
      EOC  = 1'b1;
      @(negedge clk);
      EOC  = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; EOC = 1'b1; D_in = 4'h5; avg_sel = 2'd0; clr = 1'b0; out_ready = 1'b0;
      #12;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
      // EOC held high across release must not capture
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      EOC = 1'b0;
      @(negedge clk);
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_eoc_high got=%0d exp=0", count); end
   endtask

   task automatic test_single();
      avg_sel = 2'd0;
      pulse(4'hA);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'hA) begin failures++; $display("FAIL single_data got=%h exp=a", out_data); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      pop_one();
      checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_pop count=%0d valid=%b exp=0/0", count, out_valid); end
      pop_one();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL empty_pop got=%0d exp=0", count); end
   endtask

   task automatic test_avg4();
      avg_sel = 2'd2;
      pulse(4'd3);
      avg_sel = 2'd0;
      pulse(4'd4);
      pulse(4'd5);
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL avg4_partial got=%0d exp=0", count); end
      pulse(4'd6);
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL avg4_count got=%0d exp=1", count); end
      checks++; if (out_data !== 4'd4) begin failures++; $display("FAIL avg4_data got=%0d exp=4", out_data); end
      pop_one();
   endtask

   task automatic test_overflow();
      avg_sel = 2'd0;
      for (int i = 1; i <= 9; i++) pulse(4'(i));
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (out_data !== 4'd1) begin failures++; $display("FAIL ovf_head got=%0d exp=1", out_data); end
      do_clr();
      checks++; if (count !== 4'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL clr count=%0d ovf=%b valid=%b exp=0/0/0", count, overflow, out_valid);
      end
   endtask

   task automatic test_full_push_pop();
      logic [3:0] exp_q [$];
      avg_sel = 2'd0;
      for (int i = 1; i <= 8; i++) pulse(4'(i));
      for (int i = 2; i <= 8; i++) exp_q.push_back(4'(i));
      exp_q.push_back(4'hC);
      @(negedge clk);
      D_in = 4'hC; EOC = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      EOC = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL fullpp_count got=%0d exp=8", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (out_data !== exp_q[i]) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, out_data, exp_q[i]); end
         pop_one();
      end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", count); end
   endtask

   task automatic test_eoc_held();
      avg_sel = 2'd0;
      @(negedge clk);
      D_in = 4'd7; EOC = 1'b1;
      @(negedge clk);
      D_in = 4'd9;
      repeat (4) @(negedge clk);
      EOC = 1'b0;
      pulse(4'd2);
      checks++; if (count !== 4'd2) begin failures++; $display("FAIL held_count got=%0d exp=2", count); end
      checks++; if (out_data !== 4'd7) begin failures++; $display("FAIL held_head got=%0d exp=7", out_data); end
      pop_one();
      checks++; if (out_data !== 4'd2) begin failures++; $display("FAIL held_second got=%0d exp=2", out_data); end
   endtask

   task automatic test_back_to_back();
      // one entry (2) remains; push and pop together keep count at 1
      @(negedge clk);
      D_in = 4'hE; EOC = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      EOC = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", count); end
      checks++; if (out_data !== 4'hE) begin failures++; $display("FAIL b2b_data got=%h exp=e", out_data); end
   endtask

   task automatic test_reset_mid();
      avg_sel = 2'd3;
      for (int i = 0; i < 5; i++) pulse(4'hF);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 4'h0 || overflow !== 1'b0) begin
         failures++; $display("FAIL rstmid count=%0d valid=%b data=%h ovf=%b exp=0", count, out_valid, out_data, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) pulse(4'(i));
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL rstmid_partial got=%0d exp=0", count); end
      pulse(4'd8);
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", count); end
      checks++; if (out_data !== 4'd4) begin failures++; $display("FAIL rstmid_data got=%0d exp=4", out_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_avg4();
      test_overflow();
      test_full_push_pop();
      test_eoc_held();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
